// File: rtl/mips_prog_loader_if.sv
// Host link of the program loader: program-word stream in, register-dump stream out.
// master = host side, slave = loader side.
interface mips_prog_loader_if;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/mips_prog_loader.sv
// Loads a program into MIPS_32 instruction memory, runs the core until HALTED
// (or a run timeout), then streams registers R0..R(NUM_DUMP-1) back to the host.
module mips_prog_loader #(
    parameter int unsigned AW       = 10,
    parameter int unsigned NUM_DUMP = 6,
    parameter int unsigned TO_W     = 16
) (
    input  logic                clk1,
    input  logic                rst_n,
    input  logic                start,
    input  logic [AW:0]         prog_len,
    mips_prog_loader_if.slave   host,
    output logic                mem_we,
    output logic [AW-1:0]       mem_addr,
    output logic [31:0]         mem_wdata,
    output logic                cpu_start,
    input  logic                cpu_halted,
    output logic [4:0]          reg_raddr,
    input  logic [31:0]         reg_rdata,
    output logic                busy,
    output logic                done,
    output logic                timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN_GO,
        S_RUN_WAIT,
        S_DUMP_RD,
        S_DUMP_CAP,
        S_DUMP_OUT,
        S_DONE
    } state_t;

    localparam logic [4:0] LAST_K = 5'(NUM_DUMP - 1);

    state_t          state, nstate;
    logic [AW:0]     len_q;
    logic [AW:0]     cnt_q;
    logic [TO_W-1:0] to_q;
    logic [TO_W-1:0] to_inc;
    logic [4:0]      k_q;
    logic            out_valid_q;
    logic [31:0]     out_data_q;
    logic            timeout_q;
    logic            load_fire;
    logic            out_fire;
    logic            to_hit;

    assign to_inc         = to_q + TO_W'(1);
    assign host.out_valid = out_valid_q;
    assign host.out_data  = out_data_q;
    assign timeout        = timeout_q;

    always_comb begin
        nstate        = state;
        host.in_ready = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        cpu_start     = 1'b0;
        reg_raddr     = '0;
        busy          = 1'b1;
        done          = 1'b0;
        load_fire     = 1'b0;
        out_fire      = 1'b0;
        to_hit        = 1'b0;
        unique case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) nstate = (prog_len == '0) ? S_RUN_GO : S_LOAD;
            end
            S_LOAD: begin
                host.in_ready = 1'b1;
                if (host.in_valid) begin
                    load_fire = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = cnt_q[AW-1:0];
                    mem_wdata = host.in_data;
                    if (cnt_q + (AW+1)'(1) == len_q) nstate = S_RUN_GO;
                end
            end
            S_RUN_GO: begin
                cpu_start = 1'b1;
                nstate    = S_RUN_WAIT;
            end
            S_RUN_WAIT: begin
                // halt is checked first so it wins over a simultaneous terminal count
                if (cpu_halted) begin
                    nstate = S_DUMP_RD;
                end else if (&to_inc) begin
                    to_hit = 1'b1;
                    nstate = S_DUMP_RD;
                end
            end
            S_DUMP_RD: begin
                reg_raddr = k_q;
                nstate    = S_DUMP_CAP;
            end
            S_DUMP_CAP: begin
                reg_raddr = k_q;
                nstate    = S_DUMP_OUT;
            end
            S_DUMP_OUT: begin
                reg_raddr = k_q;
                if (host.out_ready) begin
                    out_fire = 1'b1;
                    if (k_q == LAST_K) begin
                        nstate = S_DONE;
                    end else begin
                        // next read issued in the handshake cycle: one bubble per word
                        reg_raddr = k_q + 5'd1;
                        nstate    = S_DUMP_CAP;
                    end
                end
            end
            S_DONE: begin
                busy   = 1'b0;
                done   = 1'b1;
                nstate = S_IDLE;
            end
            default: nstate = S_IDLE;
        endcase
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            len_q       <= '0;
            cnt_q       <= '0;
            to_q        <= '0;
            k_q         <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state <= nstate;

            if (state == S_IDLE && start) begin
                len_q     <= prog_len;
                cnt_q     <= '0;
                k_q       <= '0;
                timeout_q <= 1'b0;
            end

            if (load_fire) cnt_q <= cnt_q + (AW+1)'(1);

            if (state == S_RUN_GO) begin
                to_q <= '0;
            end else if (state == S_RUN_WAIT && !cpu_halted) begin
                to_q <= to_inc;
            end

            if (to_hit) timeout_q <= 1'b1;

            if (state == S_DUMP_CAP) begin
                out_valid_q <= 1'b1;
                out_data_q  <= reg_rdata;
            end else if (out_fire) begin
                out_valid_q <= 1'b0;
            end

            if (out_fire) k_q <= k_q + 5'd1;
        end
    end

endmodule

// File: tb/tb_mips_prog_loader.sv
// Scoreboard bench for mips_prog_loader with a behavioural MIPS_32 core model
// (instruction-level interpreter over a small instruction memory).
module tb_mips_prog_loader;

    localparam int AW       = 4;
    localparam int NUM_DUMP = 6;
    localparam int TO_W     = 4;
    localparam int MEMN     = 1 << AW;

    typedef logic [31:0] mem_t [MEMN];
    typedef logic [31:0] reg_t [32];

    logic            clk1 = 1'b0;
    logic            rst_n;
    logic            start;
    logic [AW:0]     prog_len;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [31:0]     mem_wdata;
    logic            cpu_start;
    logic            cpu_halted = 1'b0;
    logic [4:0]      reg_raddr;
    logic [31:0]     reg_rdata;
    logic            busy, done, timeout;

    mips_prog_loader_if host ();

    mips_prog_loader #(.AW(AW), .NUM_DUMP(NUM_DUMP), .TO_W(TO_W)) dut (
        .clk1(clk1), .rst_n(rst_n), .start(start), .prog_len(prog_len), .host(host),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_start(cpu_start), .cpu_halted(cpu_halted),
        .reg_raddr(reg_raddr), .reg_rdata(reg_rdata),
        .busy(busy), .done(done), .timeout(timeout)
    );

    always #5 clk1 = ~clk1;

    int cyc = 0;
    always @(posedge clk1) cyc <= cyc + 1;

    // Instruction-level reference: ADD/SUB/AND/OR/ADDI/HLT, registers start at Rk=k.
    function automatic void run_prog(input mem_t m, output reg_t r, output bit h);
        int unsigned pc;
        logic [31:0] ins;
        logic [31:0] v;
        for (int k = 0; k < 32; k++) r[k] = 32'(k);
        h  = 1'b0;
        pc = 0;
        for (int s = 0; s < 64; s++) begin
            ins = m[pc % MEMN];
            pc++;
            if (ins[31:26] == 6'h3f) begin
                h = 1'b1;
                break;
            end
            v = r[ins[15:11]];
            case (ins[31:26])
                6'h00: v = r[ins[25:21]] + r[ins[20:16]];
                6'h01: v = r[ins[25:21]] - r[ins[20:16]];
                6'h02: v = r[ins[25:21]] & r[ins[20:16]];
                6'h03: v = r[ins[25:21]] | r[ins[20:16]];
                default: ;
            endcase
            if (ins[31:26] <= 6'h03 && ins[15:11] != 5'd0) r[ins[15:11]] = v;
            if (ins[31:26] == 6'h0a && ins[20:16] != 5'd0)
                r[ins[20:16]] = r[ins[25:21]] + {{16{ins[15]}}, ins[15:0]};
        end
    endfunction

    // Core model: owns imem and the register file; halts a few cycles after cpu_start.
    mem_t        imem;
    reg_t        core_regs;
    reg_t        core_tmp;
    bit          core_h;
    bit          never_halt = 1'b0;
    bit          halt_go = 1'b0;
    int          halt_cd = 0;
    logic        preload_en = 1'b0;
    logic [31:0] preload_data = '0;

    always @(posedge clk1) begin
        reg_rdata <= core_regs[reg_raddr];
        if (preload_en) imem[0] <= preload_data;
        if (mem_we) imem[mem_addr] <= mem_wdata;
        if (cpu_start) begin
            run_prog(imem, core_tmp, core_h);
            if (never_halt) for (int k = 0; k < 32; k++) core_regs[k] <= 32'(k);
            else core_regs <= core_tmp;
            halt_go    <= core_h && !never_halt;
            halt_cd    <= int'($urandom_range(1, 8));
            cpu_halted <= 1'b0;
        end else if (halt_go && halt_cd > 0) begin
            halt_cd <= halt_cd - 1;
            if (halt_cd == 1) cpu_halted <= 1'b1;
        end
    end

    int total = 0;
    int bad   = 0;

    logic [AW+31:0] exp_mem [$];
    logic [31:0]    exp_dump [$];
    mem_t           ref_mem;
    logic [31:0]    prog_w [32];
    bit             bp_mode = 1'b0;
    int             tot_cs = 0, tot_ir = 0, cs_cyc = 0, to_cyc = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h required=%0h", nm, got, exp);
        end
    endtask

    function automatic logic outs_any();
        return |{mem_we, mem_addr, mem_wdata, cpu_start, reg_raddr, host.in_ready,
                 host.out_valid, host.out_data, busy, done, timeout};
    endfunction

    task automatic load_demo();
        logic [31:0] d [9] = '{32'h2801000a, 32'h28020014, 32'h28030019, 32'h0ce77800,
                               32'h0ce77800, 32'h00222000, 32'h0ce77800, 32'h00832800,
                               32'hfc000000};
        for (int j = 0; j < 9; j++) prog_w[j] = d[j];
    endtask

    task automatic rand_prog(input int len);
        logic [4:0] a, b, c;
        for (int j = 0; j < len - 1; j++) begin
            a = 5'($urandom_range(0, 7));
            b = 5'($urandom_range(1, 7));
            c = 5'($urandom_range(1, 7));
            case ($urandom_range(0, 3))
                0: prog_w[j] = {6'h0a, a, b, 16'($urandom)};
                1: prog_w[j] = {6'h00, a, b, c, 11'd0};
                2: prog_w[j] = {6'h01, a, b, c, 11'd0};
                default: prog_w[j] = {6'h03, a, b, c, 11'd0};
            endcase
        end
        prog_w[len-1] = 32'hfc000000;
    endtask

    // One load/run/dump sequence; abort_at >= 0 resets the DUT after that many accepted words.
    task automatic run_seq(input int len, input bit bp, input bit nh, input int abort_at);
        int   i, guard, lim, base_cs, base_ir, start_cyc;
        reg_t r;
        bit   h, exp_to;
        never_halt = nh;
        bp_mode    = bp;
        for (int j = 0; j < len; j++) exp_mem.push_back({AW'(j), prog_w[j]});
        base_cs = tot_cs;
        base_ir = tot_ir;
        @(negedge clk1);
        start     = 1'b1;
        prog_len  = (AW+1)'(len);
        start_cyc = cyc;
        @(negedge clk1);
        start    = 1'b0;
        prog_len = (AW+1)'($urandom);
        chk("busy_after_start", {63'd0, busy}, 64'd1);
        chk("timeout_cleared", {63'd0, timeout}, 64'd0);
        lim   = (abort_at >= 0) ? abort_at : len;
        i     = 0;
        guard = 0;
        while (i < lim && guard < 2000) begin
            if (bp && $urandom_range(0, 2) == 0) begin
                host.in_valid = 1'b0;
            end else begin
                host.in_valid = 1'b1;
                host.in_data  = prog_w[i];
            end
            start    = bp && (i == 2);
            prog_len = 5;
            if (host.in_valid && host.in_ready) begin
                ref_mem[i % MEMN] = prog_w[i];
                i++;
            end
            @(negedge clk1);
            guard++;
        end
        host.in_valid = 1'b0;
        start         = 1'b0;
        chk("load_words_accepted", 64'(i), 64'(lim));
        if (!bp) chk("load_cycles", 64'(guard), 64'(lim));

        if (abort_at >= 0) begin
            host.in_valid = 1'b1;
            host.in_data  = $urandom;
            rst_n         = 1'b0;
            #2;
            chk("outputs_in_reset", {63'd0, outs_any()}, 64'd0);
            exp_mem.delete();
            exp_dump.delete();
            repeat (2) @(negedge clk1);
            rst_n         = 1'b1;
            host.in_valid = 1'b0;
            return;
        end

        if (nh) begin
            for (int k = 0; k < 32; k++) r[k] = 32'(k);
            h = 1'b0;
        end else begin
            run_prog(ref_mem, r, h);
        end
        exp_to = nh || !h;
        for (int k = 0; k < NUM_DUMP; k++) exp_dump.push_back(r[k]);

        start    = 1'b1;
        prog_len = 3;
        @(negedge clk1);
        start = 1'b0;

        guard = 0;
        while (!done && guard < 400) begin
            @(negedge clk1);
            guard++;
        end
        chk("done_seen", {63'd0, done}, 64'd1);
        chk("timeout_flag", {63'd0, timeout}, {63'd0, exp_to});
        chk("cpu_start_pulses", 64'(tot_cs - base_cs), 64'd1);
        chk("dump_words_left", 64'(exp_dump.size()), 64'd0);
        if (len == 0) begin
            chk("zero_len_in_ready", 64'(tot_ir - base_ir), 64'd0);
            chk("zero_len_cpu_start_delay",
                {63'd0, (cs_cyc - start_cyc >= 1) && (cs_cyc - start_cyc <= 2)}, 64'd1);
        end
        if (exp_to) chk("timeout_delay", 64'(to_cyc - cs_cyc), 64'(1 << TO_W));
        @(negedge clk1);
        chk("idle_after_done", {62'd0, busy, done}, 64'd0);
        exp_dump.delete();
    endtask

    initial begin
        logic           prev_hold = 1'b0;
        logic           prev_to   = 1'b0;
        logic [31:0]    prev_data = '0;
        logic [AW+31:0] e;
        int             hold_n = 0;

        rst_n          = 1'b0;
        start          = 1'b0;
        prog_len       = '0;
        host.in_valid  = 1'b0;
        host.in_data   = '0;
        host.out_ready = 1'b0;

        fork
            forever begin
                @(negedge clk1);
                #2;
                if (!rst_n) begin
                    prev_hold = 1'b0;
                    prev_to   = 1'b0;
                    continue;
                end
                if (cpu_start) begin
                    tot_cs++;
                    cs_cyc = cyc;
                end
                if (timeout && !prev_to) to_cyc = cyc;
                prev_to = timeout;
                if (host.in_ready) tot_ir++;
                if (mem_we) begin
                    if (exp_mem.size() == 0) begin
                        chk("mem_write_unexpected", {60'd0, mem_addr}, 64'hffff);
                    end else begin
                        e = exp_mem.pop_front();
                        chk("mem_write", 64'({mem_addr, mem_wdata}), 64'(e));
                    end
                end
                if (host.out_valid && prev_hold)
                    chk("out_data_stable", 64'(host.out_data), 64'(prev_data));
                if (host.out_valid && host.out_ready) begin
                    if (exp_dump.size() == 0) begin
                        chk("dump_unexpected", 64'(host.out_data), 64'hffff_ffff_ffff);
                    end else begin
                        chk("dump_word", 64'(host.out_data), 64'(exp_dump.pop_front()));
                    end
                end
                prev_hold = host.out_valid && !host.out_ready;
                prev_data = host.out_data;
            end
            forever begin
                @(negedge clk1);
                if (!bp_mode) begin
                    host.out_ready = 1'b1;
                end else if (host.out_valid) begin
                    if (hold_n == 3) begin
                        host.out_ready = 1'b1;
                        hold_n = 0;
                    end else begin
                        host.out_ready = 1'b0;
                        hold_n++;
                    end
                end else begin
                    host.out_ready = 1'b0;
                end
            end
        join_none

        repeat (3) @(negedge clk1);
        host.in_valid = 1'b1;
        host.in_data  = 32'hdeadbeef;
        #2;
        chk("reset_outputs", {63'd0, outs_any()}, 64'd0);
        host.in_valid = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk1);

        load_demo();
        run_seq(9, 1'b0, 1'b0, -1);
        run_seq(9, 1'b1, 1'b0, -1);

        @(negedge clk1);
        preload_en   = 1'b1;
        preload_data = 32'hfc000000;
        ref_mem[0]   = 32'hfc000000;
        @(negedge clk1);
        preload_en = 1'b0;
        run_seq(0, 1'b0, 1'b0, -1);

        load_demo();
        run_seq(9, 1'b0, 1'b1, -1);
        run_seq(9, 1'b0, 1'b0, -1);

        run_seq(9, 1'b0, 1'b0, 4);
        prog_w[0] = 32'h28010007;
        prog_w[1] = 32'hfc000000;
        run_seq(2, 1'b0, 1'b0, -1);

        for (int t = 0; t < 8; t++) begin
            int len;
            len = int'($urandom_range(1, 20));
            rand_prog(len);
            run_seq(len, 1'($urandom_range(0, 1)), 1'b0, -1);
        end

        repeat (2) @(negedge clk1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mips_prog_loader.md
Name: mips_prog_loader

Overview:
- Host-side loader/dumper for the MIPS_32 core. It replaces the hierarchical memory pokes and register peeks done by testbenches with real hardware.
- Accepts a program as a valid/ready stream of 32-bit words and writes them to instruction memory from address 0.
- Then releases the core, waits for HALTED, and streams registers R0..R(NUM_DUMP-1) out on a valid/ready port.
- Sits between the host link and the core's memory write port and register-file read port.

Parameters:
- AW, 10, instruction memory address width in words.
- NUM_DUMP, 6, number of registers dumped, starting at R0. Legal range 1..32.
- TO_W, 16, width of the run-timeout counter. Timeout occurs at 2^TO_W-1 cycles.

Ports:
- clk1  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a load/run/dump sequence.
- prog_len  in  AW+1  number of words to load, sampled when start is accepted.
- in_valid  in  1  program word valid.
- in_data  in  32  program word.
- in_ready  out  1  loader accepts in_data.
- mem_we  out  1  instruction memory write enable.
- mem_addr  out  AW  instruction memory write address.
- mem_wdata  out  32  instruction memory write data.
- cpu_start  out  1  one-cycle pulse. The core clears PC, HALTED and TAKEN_BRANCH and begins fetching.
- cpu_halted  in  1  core HALTED flag.
- reg_raddr  out  5  register-file read address.
- reg_rdata  in  32  register data, valid one cycle after reg_raddr.
- out_valid  out  1  dump word valid.
- out_data  out  32  dump word.
- out_ready  in  1  host accepts the dump word.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle pulse at end of sequence.
- timeout  out  1  sticky; the run phase timed out. Cleared on next accepted start.

Behaviour:
- Reset values: every output is 0; state is IDLE; all counters are 0.
- IDLE
  - start=1 is accepted: latch prog_len, clear timeout, set busy=1.
  - Go to LOAD, or to RUN if prog_len==0.
  - start is ignored in every state other than IDLE.
- LOAD
  - in_ready=1.
  - Each cycle with in_valid&in_ready: mem_we=1, mem_addr=word count, mem_wdata=in_data (combinational from in_data in the same cycle), then increment the count.
  - After the word at count prog_len-1 is accepted, go to RUN next cycle.
  - in_valid is ignored outside LOAD.
  - If prog_len exceeds 2^AW, the address wraps modulo 2^AW. The word count still terminates at prog_len.
- RUN
  - First cycle: cpu_start=1 for exactly one cycle; clear the timeout counter.
  - cpu_halted is evaluated from the cycle after cpu_start. A stale HALTED from a previous program is therefore never seen.
  - cpu_halted=1: go to DUMP.
  - Otherwise the counter increments. On reaching all-ones, set timeout=1 and go to DUMP anyway, so partial state is visible.
- DUMP
  - Issue reg_raddr=k, starting at k=0.
  - Next cycle: capture reg_rdata into out_data and assert out_valid.
  - out_valid and out_data are held stable until out_ready=1.
  - On the handshake, k increments and the next read is issued in that same cycle. This gives one bubble cycle per word.
  - After word NUM_DUMP-1 is accepted, go to DONE.
- DONE
  - done=1 for one cycle, busy=0, return to IDLE.
- Simultaneous events: out_ready=1 with out_valid=0 has no effect. cpu_halted asserting in the same cycle as the timeout terminal count takes the halt path (timeout stays 0).
- Reset mid-operation (any state): return immediately to IDLE with all outputs 0. A partially loaded memory is not cleared.
- Throughput: LOAD sustains 1 word/cycle. DUMP delivers 1 word per 2 cycles when out_ready is held high.

Test Plan:
- Full sequence
  - Stimulus: core registers Rk=k; start with prog_len=9; stream 2801000a, 28020014, 28030019, 0ce77800, 0ce77800, 00222000, 0ce77800, 00832800, fc000000 back-to-back.
  - Required: mem writes at addresses 0..8 in order, one per cycle; a single cpu_start pulse; dump 0, 10, 20, 25, 30, 55 (R0..R5); done pulse; timeout=0.
- Backpressure
  - Stimulus: same program, with in_valid toggling and out_ready low for 3 cycles per word.
  - Required: no missed or duplicated mem writes; out_data stable while out_valid&!out_ready; same six dump values.
- Zero-length program
  - Stimulus: prog_len=0, memory preloaded with the halt word fc000000 at address 0.
  - Required: no in_ready or mem_we assertion; cpu_start within 2 cycles of start; dump R0..R5 = 0..5.
- Timeout
  - Stimulus: TO_W=4; cpu_halted tied 0.
  - Required: timeout=1 after 15 RUN cycles; dump still produced; done pulses; next start clears timeout.
- Reset and start handling
  - Stimulus: assert rst_n=0 after the 4th accepted word; then new start with prog_len=2.
  - Required: all outputs 0 during reset; new load writes addresses 0 and 1.
  - Stimulus: start asserted again while busy.
  - Required: ignored.
